ps2_cmd_scheduler: RTL and testbench

Shares the PS2 host-to-device command channel of `PS2_Controller` between `NUM_REQ` requesters, such as keyboard LED update, typematic config and init/reset. It arbitrates requests round-robin, drives `the_command`/`send_command`, then waits for the device's ACK (0xFA) and retries on RESEND (0xFE). Received bytes that are not command responses pass through untouched as scan data. It sits between the application logic and `PS2_Controller` in the PS2_Keyboard path.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_rr_arbiter.sv | 31 +++
 rtl/ps2_cmd_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_ps2_cmd_scheduler.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared states and constants for the PS2 host-to-device command scheduler.
// PS2_CMD_RESEND_EN (see ps2_cmd_scheduler) enables 0xFE retry handling.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_RELEASE,
        ST_WAIT_ACK
    } ps2_state_t;

    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;

    // 20 ms at 50 MHz
    localparam int PS2_ACK_TIMEOUT_DEF = 1_000_000;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/ps2_rr_arbiter.sv
// Combinational round-robin pick: search starts at i_ptr and wraps.
// Returns a one-hot grant, the granted index and an any-valid flag.
module ps2_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IW      = 1
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [IW-1:0]      i_ptr,
    output logic               o_any,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IW-1:0]      o_idx
);

    logic [IW-1:0] w_j;

    always_comb begin
        o_any = 1'b0;
        o_gnt = '0;
        o_idx = '0;
        w_j   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_j = IW'((int'(i_ptr) + k) % NUM_REQ);
            if (!o_any && i_valid[w_j]) begin
                o_any      = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_idx      = w_j;
            end
        end
    end

endmodule

// File: rtl/ps2_cmd_scheduler.sv
// Round-robin sharing of the PS2 command channel with ACK wait and scan pass-through.
// Define PS2_CMD_RESEND_EN to retry on 0xFE (up to MAX_RETRY) instead of failing.
module ps2_cmd_scheduler
    import ps2_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ACK_TIMEOUT = PS2_ACK_TIMEOUT_DEF,
    parameter int MAX_RETRY   = 3
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_cmd,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [NUM_REQ-1:0]   req_done,
    output logic [NUM_REQ-1:0]   req_error,
    output logic                 busy,
    output logic [7:0]           ps2_command,
    output logic                 ps2_send_command,
    input  logic                 ps2_command_was_sent,
    input  logic                 ps2_error_timed_out,
    input  logic [7:0]           ps2_received_data,
    input  logic                 ps2_received_data_en,
    output logic [7:0]           scan_data,
    output logic                 scan_valid
);

    localparam int IW = clog2_min1(NUM_REQ);
    localparam int TW = clog2_min1(ACK_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    if (NUM_REQ < 1 || NUM_REQ > 8 || ACK_TIMEOUT < 1 || MAX_RETRY < 0) begin : g_param_chk
        $error("ps2_cmd_scheduler: parameter out of range");
    end

    ps2_state_t         r_state;
    ps2_state_t         w_state_nxt;
    logic [7:0]         r_cmd;
    logic [IW-1:0]      r_idx;
    logic [IW-1:0]      r_rr_ptr;
    logic               r_rel_err;
    logic [TW-1:0]      r_tmo;
    logic [NUM_REQ-1:0] r_ack;
    logic [NUM_REQ-1:0] r_done;
    logic [NUM_REQ-1:0] r_err;
    logic [7:0]         r_scan_data;
    logic               r_scan_valid;

    logic               w_any;
    logic [NUM_REQ-1:0] w_gnt;
    logic [IW-1:0]      w_gnt_idx;
    logic [7:0]         w_sel_cmd;
    logic [NUM_REQ-1:0] w_owner;
    logic               w_rsp_ack;
    logic               w_rsp_rsd;
    logic               w_capture;
    logic               w_done;
    logic               w_fail;
    logic               w_consume;
    logic               w_rel_err_nxt;

`ifdef PS2_CMD_RESEND_EN
    localparam int RW = clog2_min1(MAX_RETRY + 1);
    logic [RW-1:0] r_retry;
    logic          w_retry_inc;
`endif

    ps2_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_arb (
        .i_valid (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_any   (w_any),
        .o_gnt   (w_gnt),
        .o_idx   (w_gnt_idx)
    );

    assign w_sel_cmd = req_cmd[{w_gnt_idx, 3'b000} +: 8];
    assign w_owner   = NUM_REQ'(1) << r_idx;
    assign w_rsp_ack = ps2_received_data_en && (ps2_received_data == PS2_ACK);
    assign w_rsp_rsd = ps2_received_data_en && (ps2_received_data == PS2_RESEND);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_capture     = 1'b0;
        w_done        = 1'b0;
        w_fail        = 1'b0;
        w_consume     = 1'b0;
        w_rel_err_nxt = r_rel_err;
`ifdef PS2_CMD_RESEND_EN
        w_retry_inc   = 1'b0;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (ps2_error_timed_out) begin
                    w_rel_err_nxt = 1'b1;
                    w_state_nxt   = ST_RELEASE;
                end else if (ps2_command_was_sent) begin
                    w_rel_err_nxt = 1'b0;
                    w_state_nxt   = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_fail      = r_rel_err;
                w_state_nxt = r_rel_err ? ST_IDLE : ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                w_consume = w_rsp_ack || w_rsp_rsd;
                // a response in the timeout cycle takes priority
                if (w_rsp_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_rsp_rsd) begin
`ifdef PS2_CMD_RESEND_EN
                    if (r_retry < RW'(MAX_RETRY)) begin
                        w_retry_inc = 1'b1;
                        w_state_nxt = ST_SEND;
                    end else begin
                        w_fail      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
`else
                    w_fail      = 1'b1;
                    w_state_nxt = ST_IDLE;
`endif
                end else if (r_tmo == TMO_LAST) begin
                    w_fail      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_cmd        <= '0;
            r_idx        <= '0;
            r_rr_ptr     <= '0;
            r_rel_err    <= 1'b0;
            r_tmo        <= '0;
            r_ack        <= '0;
            r_done       <= '0;
            r_err        <= '0;
            r_scan_data  <= '0;
            r_scan_valid <= 1'b0;
        end else begin
            r_ack     <= '0;
            r_done    <= w_done ? w_owner : '0;
            r_err     <= w_fail ? w_owner : '0;
            r_rel_err <= w_rel_err_nxt;
            if (w_capture) begin
                r_cmd    <= w_sel_cmd;
                r_idx    <= w_gnt_idx;
                r_ack    <= w_gnt;
                r_rr_ptr <= (w_gnt_idx == IW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + IW'(1);
            end
            if (r_state == ST_RELEASE)
                r_tmo <= '0;
            else if (r_state == ST_WAIT_ACK && r_tmo != '1)
                r_tmo <= r_tmo + TW'(1);
            r_scan_valid <= ps2_received_data_en && !w_consume;
            if (ps2_received_data_en && !w_consume)
                r_scan_data <= ps2_received_data;
        end
    end

`ifdef PS2_CMD_RESEND_EN
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)            r_retry <= '0;
        else if (w_capture)   r_retry <= '0;
        else if (w_retry_inc) r_retry <= r_retry + RW'(1);
    end
`endif

    assign req_ack          = r_ack;
    assign req_done         = r_done;
    assign req_error        = r_err;
    assign busy             = (r_state != ST_IDLE);
    assign ps2_command      = r_cmd;
    assign ps2_send_command = (r_state == ST_SEND);
    assign scan_data        = r_scan_data;
    assign scan_valid       = r_scan_valid;

endmodule

// File: tb/tb_ps2_cmd_scheduler.sv
// Bench for ps2_cmd_scheduler: acts as the PS2 controller and requesters,
// predicting grants, pulses and scan bytes from a transaction-level model.
module tb_ps2_cmd_scheduler;

    localparam int N   = 2;
    localparam int TMO = 100;
    localparam int MR  = 3;

    localparam int SC_OK     = 0;
    localparam int SC_RESEND = 1;
    localparam int SC_TMO    = 2;
    localparam int SC_LATE   = 3;
    localparam int SC_CTLERR = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_cmd;
    logic [N-1:0]   req_ack, req_done, req_error;
    logic           busy;
    logic [7:0]     ps2_command;
    logic           ps2_send_command;
    logic           was_sent, ctl_tmo;
    logic [7:0]     rx;
    logic           rx_en;
    logic [7:0]     scan_data;
    logic           scan_valid;

    int   total = 0;
    int   bad   = 0;
    int   ptr   = 0;
    logic [7:0] cmds [N];
    bit   pend [N];

    always #5 clk = ~clk;

    ps2_cmd_scheduler #(
        .NUM_REQ     (N),
        .ACK_TIMEOUT (TMO),
        .MAX_RETRY   (MR)
    ) dut (
        .CLOCK_50             (clk),
        .reset                (rst),
        .req_valid            (req_valid),
        .req_cmd              (req_cmd),
        .req_ack              (req_ack),
        .req_done             (req_done),
        .req_error            (req_error),
        .busy                 (busy),
        .ps2_command          (ps2_command),
        .ps2_send_command     (ps2_send_command),
        .ps2_command_was_sent (was_sent),
        .ps2_error_timed_out  (ctl_tmo),
        .ps2_received_data    (rx),
        .ps2_received_data_en (rx_en),
        .scan_data            (scan_data),
        .scan_valid           (scan_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input int i, input logic [7:0] c);
        if (!pend[i]) begin
            pend[i]            = 1'b1;
            cmds[i]            = c;
            req_cmd[8*i +: 8]  = c;
            req_valid[i]       = 1'b1;
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++)
            if (pend[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic rx_byte(input logic [7:0] b);
        rx    = b;
        rx_en = 1'b1;
        tick();
        rx_en = 1'b0;
    endtask

    function automatic logic [7:0] scan_byte();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == 8'hFA || b == 8'hFE) b = 8'h1C;
        return b;
    endfunction

    // one command from grant to completion; DUT is in IDLE on entry
    task automatic run_txn(input int scen, input int nfe);
        int g;
        g = pick();
        tick();
        chk("ack", req_ack, 32'(1) << g);
        chk("cmd", ps2_command, cmds[g]);
        chk("send_rise", ps2_send_command, 1);
        pend[g]      = 1'b0;
        req_valid[g] = 1'b0;
        ptr          = (g + 1) % N;
        for (int att = 0; att <= MR; att++) begin
            repeat ($urandom_range(0, 3)) begin
                tick();
                chk("send_hold", ps2_send_command, 1);
            end
            if (scen == SC_CTLERR) begin
                ctl_tmo  = 1'b1;
                was_sent = 1'($urandom_range(0, 1));
            end else begin
                was_sent = 1'b1;
            end
            tick();
            was_sent = 1'b0;
            ctl_tmo  = 1'b0;
            chk("release", ps2_send_command, 0);
            chk("rel_busy", busy, 1);
            tick();
            if (scen == SC_CTLERR) begin
                chk("ctl_err", req_error, 32'(1) << g);
                chk("ctl_err_done", req_done, 0);
                chk("ctl_err_busy", busy, 0);
                return;
            end
            chk("wait_send", ps2_send_command, 0);
            chk("wait_err", req_error, 0);
            if (scen == SC_TMO || scen == SC_LATE) begin
                repeat (TMO - 1) tick();
                chk("pre_tmo_err", req_error, 0);
                if (scen == SC_LATE) begin
                    rx_byte(8'hFA);
                    chk("late_done", req_done, 32'(1) << g);
                    chk("late_noerr", req_error, 0);
                end else begin
                    tick();
                    chk("tmo_err", req_error, 32'(1) << g);
                    chk("tmo_busy", busy, 0);
                end
                return;
            end
            repeat ($urandom_range(0, 2)) begin
                logic [7:0] b;
                b = scan_byte();
                repeat ($urandom_range(0, 3)) tick();
                rx_byte(b);
                chk("scan_valid", scan_valid, 1);
                chk("scan_data", scan_data, b);
                chk("scan_nodone", req_done, 0);
            end
            if (scen == SC_RESEND && att < nfe) begin
                rx_byte(8'hFE);
                chk("fe_consumed", scan_valid, 0);
`ifdef PS2_CMD_RESEND_EN
                if (att < MR) begin
                    chk("resend", ps2_send_command, 1);
                    chk("resend_noerr", req_error, 0);
                    continue;
                end
`endif
                chk("fe_err", req_error, 32'(1) << g);
                chk("fe_busy", busy, 0);
                return;
            end
            rx_byte(8'hFA);
            chk("done", req_done, 32'(1) << g);
            chk("done_noerr", req_error, 0);
            chk("fa_consumed", scan_valid, 0);
            chk("done_busy", busy, 0);
            return;
        end
        chk("txn_end_reached", 0, 1);
    endtask

    initial begin
        int g;
        rst       = 1'b1;
        req_valid = '0;
        req_cmd   = '0;
        was_sent  = 1'b0;
        ctl_tmo   = 1'b0;
        rx        = '0;
        rx_en     = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        repeat (2) tick();
        chk("rst_cmd", ps2_command, 0);
        chk("rst_send", ps2_send_command, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {req_ack, req_done, req_error}, 0);
        chk("rst_scan", {scan_valid, scan_data}, 0);
        rst = 1'b0;
        tick();

        // responses outside WAIT_ACK are ordinary scan bytes
        rx_byte(8'hFA);
        chk("idle_fa_valid", scan_valid, 1);
        chk("idle_fa_data", scan_data, 8'hFA);
        rx_byte(8'hFE);
        chk("idle_fe_data", scan_data, 8'hFE);
        tick();
        chk("scan_pulse", scan_valid, 0);

        post(0, 8'hED);
        run_txn(SC_OK, 0);

        post(0, 8'hF3);
        post(1, 8'hF4);
        run_txn(SC_OK, 0);
        run_txn(SC_OK, 0);
        post(0, 8'h11);
        post(1, 8'h22);
        run_txn(SC_OK, 0);
        run_txn(SC_OK, 0);

        post(1, 8'hFF);
        run_txn(SC_RESEND, 2);
        post(0, 8'hF0);
        run_txn(SC_RESEND, 4);
        post(1, 8'hED);
        run_txn(SC_TMO, 0);
        post(0, 8'hED);
        run_txn(SC_LATE, 0);
        post(1, 8'hF6);
        run_txn(SC_CTLERR, 0);

        // reset in the middle of SEND
        post(0, 8'hAB);
        g = pick();
        tick();
        chk("mid_ack", req_ack, 32'(1) << g);
        pend[g]   = 1'b0;
        req_valid = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst_async_send", ps2_send_command, 0);
        chk("rst_async_busy", busy, 0);
        repeat (3) begin
            tick();
            chk("rst_no_pulse", {req_ack, req_done, req_error}, 0);
        end
        rst = 1'b0;
        ptr = 0;
        tick();

        for (int it = 0; it < 40; it++) begin
            int sc;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 1) == 1) post(i, 8'($urandom_range(0, 255)));
            if (pick() < 0) post(int'($urandom_range(0, N - 1)), 8'($urandom_range(0, 255)));
            sc = int'($urandom_range(0, 9));
            if (sc < 5)       run_txn(SC_OK, 0);
            else if (sc < 8)  run_txn(SC_RESEND, int'($urandom_range(1, 4)));
            else if (sc == 8) run_txn(SC_CTLERR, 0);
            else              run_txn(SC_TMO, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
